// File: rtl/onchip_mem_dual_slave.sv
// Two Avalon-MM slave ports sharing one single-port word array.
// Round-robin arbitration, byte-lane writes, pipelined reads (latency 1 or 2) with per-port return.
module onchip_mem_dual_slave #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 16,
    parameter int    DEPTH        = 65536,
    parameter int    READ_LATENCY = 1,
    parameter bit    S2_WRITABLE  = 1'b1,
    parameter string INIT_FILE    = "onchip_mem_dual_slave.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      reset_req,
    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    output logic                      s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      s2_waitrequest
);
    localparam int                  NB        = DATA_WIDTH / 8;
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  enabled;
    logic                  accept;
    logic                  s1_req, s2_req;
    logic                  s1_gnt, s2_gnt;
    logic                  last_grant_q, last_grant_d;
    logic                  sel_port;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [NB-1:0]         sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [IDX_W-1:0]      sel_idx;
    logic                  in_range;
    logic                  wr_en, rd_en;
    logic                  p1_vld_q, p1_vld_d;
    logic                  p1_port_q, p1_port_d;
    logic [DATA_WIDTH-1:0] ram1_q, ram2_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // last_grant: 0 = s1, 1 = s2
    always_comb begin
        enabled   = clken & ~reset_req;
        accept    = enabled & ~reset;
        s1_req    = s1_chipselect & (s1_read | s1_write);
        s2_req    = s2_chipselect & (s2_read | s2_write);
        s1_gnt    = s1_req & (~s2_req | last_grant_q);
        s2_gnt    = s2_req & ~s1_gnt;
        sel_port  = s2_gnt;
        sel_write = sel_port ? s2_write      : s1_write;
        sel_addr  = sel_port ? s2_address    : s1_address;
        sel_be    = sel_port ? s2_byteenable : s1_byteenable;
        sel_wdata = sel_port ? s2_writedata  : s1_writedata;
        sel_idx   = sel_addr[IDX_W-1:0];
        in_range  = {1'b0, sel_addr} < DEPTH_LIM;
        wr_en     = accept & (s1_gnt | s2_gnt) & sel_write & in_range & (~sel_port | S2_WRITABLE);
        rd_en     = accept & (s1_gnt | s2_gnt) & ~sel_write;

        last_grant_d = last_grant_q;
        if (accept & (s1_gnt | s2_gnt))
            last_grant_d = sel_port;

        p1_vld_d  = p1_vld_q;
        p1_port_d = p1_port_q;
        if (enabled) begin
            p1_vld_d = rd_en;
            if (rd_en)
                p1_port_d = sel_port;
        end
    end

    assign s1_waitrequest = s1_req & ~(accept & s1_gnt);
    assign s2_waitrequest = s2_req & ~(accept & s2_gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            p1_vld_q     <= 1'b0;
            p1_port_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            p1_vld_q     <= p1_vld_d;
            p1_port_q    <= p1_port_d;
        end
    end

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (sel_be[i])
                    mem[sel_idx][i*8 +: 8] <= sel_wdata[i*8 +: 8];
            end
        end
    end

    // RAM output register split per port so each port's readdata holds between its own returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram1_q <= '0;
            ram2_q <= '0;
        end else if (rd_en) begin
            if (sel_port)
                ram2_q <= in_range ? mem[sel_idx] : '0;
            else
                ram1_q <= in_range ? mem[sel_idx] : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  p2_vld_q, p2_vld_d;
        logic                  p2_port_q, p2_port_d;
        logic [DATA_WIDTH-1:0] out1_q, out1_d;
        logic [DATA_WIDTH-1:0] out2_q, out2_d;

        always_comb begin
            p2_vld_d  = p2_vld_q;
            p2_port_d = p2_port_q;
            out1_d    = out1_q;
            out2_d    = out2_q;
            if (enabled) begin
                p2_vld_d  = p1_vld_q;
                p2_port_d = p1_port_q;
                if (p1_vld_q && !p1_port_q)
                    out1_d = ram1_q;
                if (p1_vld_q && p1_port_q)
                    out2_d = ram2_q;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                p2_vld_q  <= 1'b0;
                p2_port_q <= 1'b0;
                out1_q    <= '0;
                out2_q    <= '0;
            end else begin
                p2_vld_q  <= p2_vld_d;
                p2_port_q <= p2_port_d;
                out1_q    <= out1_d;
                out2_q    <= out2_d;
            end
        end

        assign s1_readdata      = out1_q;
        assign s2_readdata      = out2_q;
        assign s1_readdatavalid = p2_vld_q & ~p2_port_q & ~reset;
        assign s2_readdatavalid = p2_vld_q &  p2_port_q & ~reset;
    end else begin : g_lat1
        assign s1_readdata      = ram1_q;
        assign s2_readdata      = ram2_q;
        // Masking with reset keeps a read that lands in the reset cycle from ever signalling valid.
        assign s1_readdatavalid = p1_vld_q & ~p1_port_q & ~reset;
        assign s2_readdatavalid = p1_vld_q &  p1_port_q & ~reset;
    end

endmodule

// File: tb/tb_onchip_mem_dual_slave.sv
// Drives two differently configured instances with identical stimulus and checks each
// against a cycle-level reference model of the arbitration, memory and read-return rules.
module tb_onchip_mem_dual_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clken, reset_req;
    logic        cs [2], rd [2], wr [2];
    logic [15:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [2][2];
    logic        rvalid [2][2];
    logic        wreq [2][2];

    onchip_mem_dual_slave u_dut0 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[0][0]),
        .s1_readdatavalid(rvalid[0][0]), .s1_waitrequest(wreq[0][0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[0][1]),
        .s2_readdatavalid(rvalid[0][1]), .s2_waitrequest(wreq[0][1])
    );

    onchip_mem_dual_slave #(
        .READ_LATENCY(2), .DEPTH(1024), .S2_WRITABLE(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
        .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[1][0]),
        .s1_readdatavalid(rvalid[1][0]), .s1_waitrequest(wreq[1][0]),
        .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
        .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[1][1]),
        .s2_readdatavalid(rvalid[1][1]), .s2_waitrequest(wreq[1][1])
    );

    typedef struct packed {
        logic        v;
        logic        p;
        logic [31:0] d;
    } ret_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          m_lat   [2] = '{1, 2};
    int          m_depth [2] = '{65536, 1024};
    bit          m_s2w   [2] = '{1'b1, 1'b0};
    bit          m_lg [2];
    logic [31:0] mref [2][65536];
    ret_t        hist [2][$];
    logic [31:0] m_rd [2][2];
    logic [31:0] fill_d [2048];
    bit          chk_on = 1'b0;
    bit          acc [2];
    logic        obs_v [2][2];
    logic        obs_w [2][2];
    logic [31:0] obs_d [2][2];
    int          vcnt [2][2];
    logic [31:0] got_s1 [2][$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample just after the inputs settle, compare, then advance the model past the edge.
    task automatic step();
        bit   en, ev;
        bit   rq [2];
        int   g;
        ret_t e;
        #1;
        en = clken && !reset_req;
        for (int p = 0; p < 2; p++) rq[p] = cs[p] && (rd[p] || wr[p]);
        for (int k = 0; k < 2; k++) begin
            g = -1;
            if (!reset && en) begin
                if (rq[0] && rq[1]) g = m_lg[k] ? 0 : 1;
                else if (rq[0])     g = 0;
                else if (rq[1])     g = 1;
            end
            if (k == 0) for (int p = 0; p < 2; p++) acc[p] = (g == p);
            for (int p = 0; p < 2; p++) begin
                obs_v[k][p] = rvalid[k][p];
                obs_w[k][p] = wreq[k][p];
                obs_d[k][p] = rdata[k][p];
                check_val($sformatf("d%0d_s%0d_waitreq", k, p + 1), 32'(wreq[k][p]), 32'(rq[p] && g != p));
                if (chk_on) begin
                    ev = !reset && hist[k].size() == m_lat[k] && hist[k][0].v && (hist[k][0].p == p[0]);
                    check_val($sformatf("d%0d_s%0d_valid", k, p + 1), 32'(rvalid[k][p]), 32'(ev));
                    check_val($sformatf("d%0d_s%0d_rdata", k, p + 1), rdata[k][p], m_rd[k][p]);
                    if (en && rvalid[k][p]) vcnt[k][p]++;
                    if (en && rvalid[k][p] && p == 0) got_s1[k].push_back(rdata[k][p]);
                end
            end
            if (reset) begin
                hist[k].delete();
                m_rd[k][0] = '0;
                m_rd[k][1] = '0;
                m_lg[k]    = 1'b1;
            end else if (en) begin
                e = '0;
                if (g >= 0) begin
                    m_lg[k] = (g == 1);
                    if (wr[g]) begin
                        if (int'(addr[g]) < m_depth[k] && (g == 0 || m_s2w[k]))
                            for (int i = 0; i < 4; i++)
                                if (be[g][i]) mref[k][addr[g]][i*8 +: 8] = wd[g][i*8 +: 8];
                    end else begin
                        e.v = 1'b1;
                        e.p = (g == 1);
                        e.d = (int'(addr[g]) < m_depth[k]) ? mref[k][addr[g]] : 32'h0;
                    end
                end
                hist[k].push_back(e);
                if (hist[k].size() > m_lat[k]) void'(hist[k].pop_front());
                if (hist[k].size() == m_lat[k] && hist[k][0].v) m_rd[k][hist[k][0].p] = hist[k][0].d;
            end
        end
        chk_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input int p, input bit c, input bit r, input bit w,
                         input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
        cs[p] = c; rd[p] = r; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, 16'h0, 4'h0, 32'h0);
        drive(1, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            got_s1[k].delete();
            vcnt[k][0] = 0;
            vcnt[k][1] = 0;
        end
    endtask

    function automatic logic [15:0] pick_addr();
        int a;
        a = $urandom_range(0, 23);
        return (a < 16) ? 16'(a) : 16'(16'h400 + a - 16);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          na [2];
        bit          pend [2];
        bit          prd [2], pwr [2];
        logic [15:0] pa [2];
        logic [3:0]  pbe [2];
        logic [31:0] pwd [2];
        int          t;

        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        idle_all();
        drive(0, 1, 1, 0, 16'h0010, 4'hF, 32'h0);
        step();
        check_val("rst_hold_s1", 32'(obs_w[0][0]), 32'd1);
        step();
        reset = 1'b0;
        idle_all();
        step();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("rst_valid_d%0d", k), 32'(obs_v[k][0] | obs_v[k][1]), 32'd0);
            check_val($sformatf("rst_rdata_d%0d", k), obs_d[k][0] | obs_d[k][1], 32'h0);
        end

        drive(0, 1, 0, 1, 16'h0010, 4'hF, 32'hDEADBEEF);
        step();
        check_val("wr_accept", 32'(obs_w[0][0]), 32'd0);
        drive(0, 1, 1, 0, 16'h0010, 4'hF, 32'h0);
        step();
        idle_all();
        step();
        check_val("rd_lat1_valid", 32'(obs_v[0][0]), 32'd1);
        check_val("rd_lat1_data", obs_d[0][0], 32'hDEADBEEF);
        check_val("rd_lat2_early", 32'(obs_v[1][0]), 32'd0);
        step();
        check_val("rd_lat2_valid", 32'(obs_v[1][0]), 32'd1);
        check_val("rd_lat2_data", obs_d[1][0], 32'hDEADBEEF);

        drive(1, 1, 0, 1, 16'h0010, 4'h1, 32'h000000AA);
        step();
        idle_all();
        clear_obs();
        drive(0, 1, 1, 0, 16'h0010, 4'h0, 32'h0);
        step();
        idle_all();
        repeat (3) step();
        check_val("s2_lane_w", got_s1[0].size() > 0 ? got_s1[0][0] : 32'hX, 32'hDEADBEAA);
        check_val("s2_ro_w", got_s1[1].size() > 0 ? got_s1[1][0] : 32'hX, 32'hDEADBEEF);

        for (int a = 0; a < 24; a++) begin
            logic [15:0] fa;
            fa = (a < 16) ? 16'(a) : 16'(16'h400 + a - 16);
            fill_d[fa] = $urandom;
            drive(0, 1, 0, 1, fa, 4'hF, fill_d[fa]);
            step();
        end
        idle_all();
        step();

        clear_obs();
        na[0] = 1; na[1] = 4;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 1, 0, 16'(na[0]), 4'h0, 32'h0);
            drive(1, 1, 1, 0, 16'(na[1]), 4'h0, 32'h0);
            step();
            check_val("contend_alt", 32'(obs_w[0][0] ^ obs_w[0][1]), 32'd1);
            for (int p = 0; p < 2; p++) if (acc[p]) na[p]++;
        end
        idle_all();
        repeat (3) step();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                check_val($sformatf("contend_cnt_d%0d_s%0d", k, p + 1), 32'(vcnt[k][p]), 32'd3);

        clear_obs();
        drive(0, 1, 1, 0, 16'd1, 4'h0, 32'h0); step();
        drive(0, 1, 1, 0, 16'd2, 4'h0, 32'h0); step();
        drive(0, 1, 1, 0, 16'd3, 4'h0, 32'h0);
        clken = 1'b0;
        step(); step();
        clken = 1'b1;
        step();
        idle_all();
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("stall_cnt_d%0d", k), 32'(got_s1[k].size()), 32'd3);
            for (int i = 0; i < 3; i++)
                if (i < got_s1[k].size())
                    check_val($sformatf("stall_data_d%0d_%0d", k, i), got_s1[k][i], fill_d[i + 1]);
        end

        clear_obs();
        drive(0, 1, 0, 1, 16'h0400, 4'hF, 32'hFFFFFFFF); step();
        drive(0, 1, 1, 0, 16'h0400, 4'h0, 32'h0);        step();
        drive(0, 1, 1, 0, 16'h0000, 4'h0, 32'h0);        step();
        idle_all();
        repeat (3) step();
        check_val("oor_cnt", 32'(got_s1[1].size()), 32'd2);
        if (got_s1[1].size() == 2) begin
            check_val("oor_rd_zero", got_s1[1][0], 32'h0);
            check_val("oor_rd_low", got_s1[1][1], fill_d[0]);
        end
        if (got_s1[0].size() == 2)
            check_val("inrange_0400", got_s1[0][0], 32'hFFFFFFFF);

        clear_obs();
        drive(0, 1, 1, 0, 16'd5, 4'h0, 32'h0);
        step();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 2; k++)
            check_val($sformatf("rst_drop_d%0d", k), 32'(vcnt[k][0] + vcnt[k][1]), 32'd0);

        clear_obs();
        drive(0, 1, 1, 0, 16'h0010, 4'h0, 32'h0);
        drive(1, 1, 1, 0, 16'h0004, 4'h0, 32'h0);
        step();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("tie_s1_d%0d", k), 32'(obs_w[k][0]), 32'd0);
            check_val($sformatf("tie_s2_d%0d", k), 32'(obs_w[k][1]), 32'd1);
        end
        drive(0, 0, 0, 0, 16'h0, 4'h0, 32'h0);
        step();
        idle_all();
        repeat (3) step();
        check_val("retain_d0", got_s1[0].size() > 0 ? got_s1[0][0] : 32'hX, 32'hDEADBEAA);
        check_val("retain_d1", got_s1[1].size() > 0 ? got_s1[1][0] : 32'hX, 32'hDEADBEEF);

        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 9) < 6) begin
                    pend[p] = 1'b1;
                    t       = $urandom_range(0, 9);
                    prd[p]  = (t < 5) || (t == 9);
                    pwr[p]  = (t >= 5);
                    pa[p]   = pick_addr();
                    pbe[p]  = 4'($urandom);
                    pwd[p]  = $urandom;
                end
                if (pend[p])
                    drive(p, 1, prd[p], pwr[p], pa[p], pbe[p], pwd[p]);
                else if ($urandom_range(0, 1) == 0)
                    drive(p, 0, 1'($urandom), 1'($urandom), pick_addr(), 4'($urandom), $urandom);
                else
                    drive(p, 1, 0, 0, pick_addr(), 4'($urandom), $urandom);
            end
            step();
            for (int p = 0; p < 2; p++) if (acc[p]) pend[p] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
